// File: rtl/fpu_op_scheduler_pkg.sv
// Opcodes, unit classes and return constants shared by the FPU operation scheduler.
package fpu_op_scheduler_pkg;

  typedef enum logic [2:0] {
    UNIT_SGN     = 3'd0,
    UNIT_CMP     = 3'd1,
    UNIT_ADD     = 3'd2,
    UNIT_MUL     = 3'd3,
    UNIT_ILLEGAL = 3'd4
  } fpu_unit_t;

  localparam logic [4:0] FPU_OP_ADD   = 5'd0;
  localparam logic [4:0] FPU_OP_SUB   = 5'd1;
  localparam logic [4:0] FPU_OP_MUL   = 5'd2;
  localparam logic [4:0] FPU_OP_DIV   = 5'd3;
  localparam logic [4:0] FPU_OP_SQRT  = 5'd4;
  localparam logic [4:0] FPU_OP_SGNJ  = 5'd5;
  localparam logic [4:0] FPU_OP_SGNJN = 5'd6;
  localparam logic [4:0] FPU_OP_SGNJX = 5'd7;
  localparam logic [4:0] FPU_OP_MIN   = 5'd8;
  localparam logic [4:0] FPU_OP_MAX   = 5'd9;
  localparam logic [4:0] FPU_OP_FEQ   = 5'd10;
  localparam logic [4:0] FPU_OP_FLT   = 5'd11;
  localparam logic [4:0] FPU_OP_FLE   = 5'd12;

  localparam logic [31:0] FPU_CANON_NAN = 32'h7FC00000;
  localparam logic [4:0]  FPU_FLAG_NV   = 5'b10000;

  // Codes 13..31 are unassigned and answer with a canonical NaN.
  function automatic fpu_unit_t fpu_unit_of(input logic [4:0] op);
    fpu_unit_t u;
    case (op)
      FPU_OP_ADD, FPU_OP_SUB:                       u = UNIT_ADD;
      FPU_OP_MUL, FPU_OP_DIV, FPU_OP_SQRT:          u = UNIT_MUL;
      FPU_OP_SGNJ, FPU_OP_SGNJN, FPU_OP_SGNJX:      u = UNIT_SGN;
      FPU_OP_MIN, FPU_OP_MAX, FPU_OP_FEQ,
      FPU_OP_FLT, FPU_OP_FLE:                       u = UNIT_CMP;
      default:                                      u = UNIT_ILLEGAL;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/fpu_op_scheduler_if.sv
// Core-side and unit-side handshake bundle of the FPU operation scheduler.
interface fpu_op_scheduler_if #(
  parameter int N_UNITS = 4
);
  logic                   valid_in;
  logic                   ready_out;
  logic [4:0]             op;
  logic [31:0]            a;
  logic [31:0]            b;

  logic [N_UNITS-1:0]     unit_valid_out;
  logic [N_UNITS-1:0]     unit_ready_in;
  logic [4:0]             unit_op;
  logic [31:0]            unit_a;
  logic [31:0]            unit_b;

  logic [N_UNITS-1:0]     unit_valid_in;
  logic [N_UNITS-1:0]     unit_ready_out;
  logic [32*N_UNITS-1:0]  unit_result;
  logic [5*N_UNITS-1:0]   unit_fflags;

  logic                   valid_out;
  logic                   ready_in;
  logic [31:0]            float_out;
  logic [4:0]             fflags_out;
  logic                   busy;

  modport master (
    output valid_in, op, a, b, unit_ready_in, unit_valid_in, unit_result,
           unit_fflags, ready_in,
    input  ready_out, unit_valid_out, unit_op, unit_a, unit_b,
           unit_ready_out, valid_out, float_out, fflags_out, busy
  );

  modport slave (
    input  valid_in, op, a, b, unit_ready_in, unit_valid_in, unit_result,
           unit_fflags, ready_in,
    output ready_out, unit_valid_out, unit_op, unit_a, unit_b,
           unit_ready_out, valid_out, float_out, fflags_out, busy
  );
endinterface

// File: rtl/fpu_op_scheduler_tag_fifo.sv
// In-order FIFO of issued unit tags; flush and reset clear pointers and count only.
module fpu_op_scheduler_tag_fifo
  import fpu_op_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  fpu_unit_t                    tag_i,
  input  logic                         pop_i,
  output fpu_unit_t                    head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fpu_unit_t      mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push_ok;
  logic           pop_ok;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= tag_i;
  end

endmodule

// File: rtl/fpu_op_scheduler.sv
// Issues core FPU ops to the decoded unit and returns unit results to the core in program order.
module fpu_op_scheduler
  import fpu_op_scheduler_pkg::*;
#(
  parameter int N_UNITS = 4,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  fpu_op_scheduler_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fpu_unit_t           sel;
  logic                sel_legal;
  fpu_unit_t           push_tag;
  fpu_unit_t           head;
  logic [CW-1:0]       count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  logic [N_UNITS-1:0]  unit_vld;
  logic                issue_rdy;
  logic [N_UNITS-1:0]  unit_rdy;
  logic                head_vld;
  logic [31:0]         head_res;
  logic [4:0]          head_flg;
  logic                head_illegal;
  logic                ret_vld;

  assign sel       = fpu_unit_of(bus.op);
  assign sel_legal = (sel != UNIT_ILLEGAL) && (int'(sel) < N_UNITS);
  assign push_tag  = sel_legal ? sel : UNIT_ILLEGAL;

  assign bus.unit_op = bus.op;
  assign bus.unit_a  = bus.a;
  assign bus.unit_b  = bus.b;

  // Illegal ops need no unit, so they are accepted whenever a tag slot is free.
  always_comb begin
    unit_vld  = '0;
    issue_rdy = !full;
    for (int i = 0; i < N_UNITS; i++) begin
      if (sel_legal && int'(sel) == i) begin
        unit_vld[i] = bus.valid_in && !full;
        issue_rdy   = bus.unit_ready_in[i] && !full;
      end
    end
  end

  assign bus.unit_valid_out = unit_vld;
  assign bus.ready_out      = issue_rdy;
  assign push               = bus.valid_in && issue_rdy;

  always_comb begin
    head_vld = 1'b0;
    head_res = '0;
    head_flg = '0;
    unit_rdy = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (int'(head) == i) begin
        head_vld    = bus.unit_valid_in[i];
        head_res    = bus.unit_result[32*i +: 32];
        head_flg    = bus.unit_fflags[5*i +: 5];
        unit_rdy[i] = bus.ready_in && !empty;
      end
    end
  end

  assign head_illegal = (head == UNIT_ILLEGAL);
  assign ret_vld      = !empty && (head_illegal || head_vld);
  assign pop          = ret_vld && bus.ready_in;

  assign bus.unit_ready_out = unit_rdy;
  assign bus.valid_out      = ret_vld;
  assign bus.float_out      = !ret_vld ? 32'h0 : (head_illegal ? FPU_CANON_NAN : head_res);
  assign bus.fflags_out     = !ret_vld ? 5'h0  : (head_illegal ? FPU_FLAG_NV   : head_flg);
  assign bus.busy           = (count != '0);

  fpu_op_scheduler_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (flush),
    .push_i  (push),
    .tag_i   (push_tag),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Randomised and directed bench for fpu_op_scheduler against a queue-based ordering model.
module tb_fpu_op_scheduler;
  import fpu_op_scheduler_pkg::*;

  localparam int NU    = 4;
  localparam int DEPTH = 4;
  localparam int ILL   = 4;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  f;
    int          due;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  fpu_op_scheduler_if #(.N_UNITS(NU)) bus ();

  fpu_op_scheduler #(.N_UNITS(NU), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int lat [NU] = '{1, 1, 3, 5};

  int   tagq [$];
  ent_t expq [$];
  ent_t uq [NU][$];

  logic m_push, m_pop;
  int   m_sel, m_head;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    else passed++;
  endtask

  function automatic int model_unit(input logic [4:0] op);
    case (op)
      FPU_OP_ADD, FPU_OP_SUB:                                          return 2;
      FPU_OP_MUL, FPU_OP_DIV, FPU_OP_SQRT:                             return 3;
      FPU_OP_SGNJ, FPU_OP_SGNJN, FPU_OP_SGNJX:                         return 0;
      FPU_OP_MIN, FPU_OP_MAX, FPU_OP_FEQ, FPU_OP_FLT, FPU_OP_FLE:      return 1;
      default:                                                         return ILL;
    endcase
  endfunction

  // Behaviour of the attached units (stimulus side, not the scheduler).
  function automatic ent_t unit_fn(input int u, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    ent_t e;
    e.due = 0;
    case (u)
      0: begin
        e.f = 5'h0;
        if (op == FPU_OP_SGNJN)      e.r = {~b[31], a[30:0]};
        else if (op == FPU_OP_SGNJX) e.r = {a[31] ^ b[31], a[30:0]};
        else                         e.r = {b[31], a[30:0]};
      end
      1: begin e.r = (a < b) ? a : b; e.f = {op[0], 4'b0}; end
      2: begin e.r = a + b; e.f = {4'b0, a[0]}; end
      3: begin e.r = a ^ {b[15:0], b[31:16]}; e.f = {1'b0, b == 32'h0, 3'b0}; end
      default: begin e.r = 32'h7FC00000; e.f = 5'b10000; end
    endcase
    return e;
  endfunction

  task automatic model_clear();
    tagq.delete();
    expq.delete();
    for (int i = 0; i < NU; i++) uq[i].delete();
  endtask

  task automatic drive(input logic v, input logic [4:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic ri, input logic [NU-1:0] ur, input logic fl);
    bus.valid_in      = v;
    bus.op            = o;
    bus.a             = aa;
    bus.b             = bb;
    bus.ready_in      = ri;
    bus.unit_ready_in = ur;
    flush             = fl;
  endtask

  task automatic drive_units();
    for (int i = 0; i < NU; i++) begin
      if (uq[i].size() > 0 && uq[i][0].due <= cyc) begin
        bus.unit_valid_in[i]        = 1'b1;
        bus.unit_result[32*i +: 32] = uq[i][0].r;
        bus.unit_fflags[5*i +: 5]   = uq[i][0].f;
      end else begin
        bus.unit_valid_in[i]        = 1'b0;
        bus.unit_result[32*i +: 32] = $urandom;
        bus.unit_fflags[5*i +: 5]   = 5'($urandom);
      end
    end
  endtask

  task automatic compare();
    logic [NU-1:0] e_uv, e_urdy;
    logic          e_rdy, e_vout, full;
    logic [31:0]   e_f;
    logic [4:0]    e_fl;
    int            sel;
    full = (tagq.size() == DEPTH);
    sel  = model_unit(bus.op);
    if (sel == ILL) e_rdy = !full;
    else            e_rdy = !full && bus.unit_ready_in[sel];
    e_uv = '0;
    if (sel != ILL && bus.valid_in && !full) e_uv[sel] = 1'b1;
    e_urdy = '0; e_vout = 1'b0; e_f = 32'h0; e_fl = 5'h0; m_head = -1;
    if (tagq.size() > 0) begin
      m_head = tagq[0];
      if (m_head == ILL) e_vout = 1'b1;
      else               e_vout = (uq[m_head].size() > 0) && (uq[m_head][0].due <= cyc);
      if (m_head != ILL && bus.ready_in) e_urdy[m_head] = 1'b1;
      if (e_vout) begin e_f = expq[0].r; e_fl = expq[0].f; end
    end
    m_push = bus.valid_in && e_rdy;
    m_pop  = e_vout && bus.ready_in;
    m_sel  = sel;
    chk("ready_out",      32'(bus.ready_out),      32'(e_rdy));
    chk("unit_valid_out", 32'(bus.unit_valid_out), 32'(e_uv));
    chk("unit_ready_out", 32'(bus.unit_ready_out), 32'(e_urdy));
    chk("valid_out",      32'(bus.valid_out),      32'(e_vout));
    chk("float_out",      bus.float_out,           e_f);
    chk("fflags_out",     32'(bus.fflags_out),     32'(e_fl));
    chk("busy",           32'(bus.busy),           32'(tagq.size() > 0));
    chk("unit_op",        32'(bus.unit_op),        32'(bus.op));
    chk("unit_a",         bus.unit_a,              bus.a);
    chk("unit_b",         bus.unit_b,              bus.b);
  endtask

  task automatic model_update();
    ent_t e;
    if (!reset_n || flush) begin
      model_clear();
      return;
    end
    if (m_pop) begin
      if (m_head != ILL) void'(uq[m_head].pop_front());
      void'(tagq.pop_front());
      void'(expq.pop_front());
    end
    if (m_push) begin
      e = unit_fn(m_sel, bus.op, bus.a, bus.b);
      tagq.push_back(m_sel);
      expq.push_back(e);
      if (m_sel != ILL) begin
        e.due = cyc + lat[m_sel];
        uq[m_sel].push_back(e);
      end
    end
  endtask

  task automatic step();
    drive_units();
    #1;
    compare();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [4:0] o;
    drive(1'b0, FPU_OP_ADD, 32'h0, 32'h0, 1'b0, 4'b1111, 1'b0);
    @(negedge clk);
    step();
    chk("rst_valid_out", 32'(bus.valid_out), 32'h0);
    chk("rst_busy",      32'(bus.busy),      32'h0);
    chk("rst_float",     bus.float_out,      32'h0);
    chk("rst_unit_rdy",  32'(bus.unit_ready_out), 32'h0);
    advance();
    reset_n = 1'b1;

    // single SGNJ issue
    drive(1'b1, FPU_OP_SGNJ, 32'h3F800000, 32'h80000000, 1'b1, 4'b1111, 1'b0);
    step();
    chk("t1_unit_valid", 32'(bus.unit_valid_out), 32'h1);
    chk("t1_ready_out",  32'(bus.ready_out), 32'h1);
    advance();
    drive(1'b0, FPU_OP_ADD, 32'h0, 32'h0, 1'b1, 4'b1111, 1'b0);
    step();
    chk("t1_valid_out", 32'(bus.valid_out), 32'h1);
    chk("t1_float",     bus.float_out, 32'hBF800000);
    advance();

    // ordering: ADD (3 cycles) ahead of SGNJ (1 cycle)
    drive(1'b1, FPU_OP_ADD, 32'h1, 32'h2, 1'b1, 4'b1111, 1'b0);
    step(); advance();
    drive(1'b1, FPU_OP_SGNJ, 32'h40000000, 32'h80000000, 1'b1, 4'b1111, 1'b0);
    step(); advance();
    drive(1'b0, FPU_OP_ADD, 32'h0, 32'h0, 1'b1, 4'b1111, 1'b0);
    step();
    chk("t2_sgn_held",  32'(bus.unit_ready_out[0]), 32'h0);
    chk("t2_no_valid",  32'(bus.valid_out), 32'h0);
    advance(); step();
    chk("t2_add_first", 32'(bus.unit_ready_out), 32'h4);
    chk("t2_add_res",   bus.float_out, 32'h3);
    advance(); step();
    chk("t2_sgn_second", 32'(bus.unit_ready_out), 32'h1);
    chk("t2_sgn_res",    bus.float_out, 32'hC0000000);
    advance();

    // full: no path from ready_in to ready_out
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, FPU_OP_ADD, 32'(i), 32'h10, 1'b0, 4'b1111, 1'b0);
      step(); advance();
    end
    step();
    chk("t3_full_block", 32'(bus.ready_out), 32'h0);
    chk("t3_full_busy",  32'(bus.busy), 32'h1);
    advance();
    step(); advance();
    bus.ready_in = 1'b1;
    step();
    chk("t3_no_bypass", 32'(bus.ready_out), 32'h0);
    chk("t3_head_vld",  32'(bus.valid_out), 32'h1);
    advance();
    bus.ready_in = 1'b0;
    step();
    chk("t3_one_freed", 32'(bus.ready_out), 32'h1);
    advance();
    step();
    chk("t3_full_again", 32'(bus.ready_out), 32'h0);
    advance();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, FPU_OP_ADD, 32'h0, 32'h0, 1'b1, 4'b1111, 1'b0);
      step(); advance();
    end

    // illegal op
    drive(1'b1, 5'd31, 32'h5, 32'h6, 1'b1, 4'b1111, 1'b0);
    step();
    chk("t4_no_unit",  32'(bus.unit_valid_out), 32'h0);
    chk("t4_accepted", 32'(bus.ready_out), 32'h1);
    advance();
    drive(1'b0, FPU_OP_ADD, 32'h0, 32'h0, 1'b1, 4'b1111, 1'b0);
    step();
    chk("t4_valid", 32'(bus.valid_out), 32'h1);
    chk("t4_nan",   bus.float_out, 32'h7FC00000);
    chk("t4_nv",    32'(bus.fflags_out), 32'h10);
    advance();
    drive(1'b1, FPU_OP_MUL, 32'h7, 32'h9, 1'b1, 4'b1111, 1'b0);
    step(); advance();
    drive(1'b1, 5'd20, 32'h0, 32'h0, 1'b1, 4'b1111, 1'b0);
    step(); advance();
    drive(1'b0, FPU_OP_ADD, 32'h0, 32'h0, 1'b1, 4'b1111, 1'b0);
    step();
    chk("t4_ill_waits", 32'(bus.valid_out), 32'h0);
    advance();
    for (int i = 0; i < 8; i++) begin step(); advance(); end

    // flush with valid_in
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, FPU_OP_ADD, 32'(i), 32'h1, 1'b0, 4'b1111, 1'b0);
      step(); advance();
    end
    drive(1'b1, FPU_OP_SGNJ, 32'h1, 32'h1, 1'b0, 4'b1111, 1'b1);
    step();
    chk("t5_busy_before", 32'(bus.busy), 32'h1);
    advance();
    drive(1'b0, FPU_OP_ADD, 32'h0, 32'h0, 1'b1, 4'b1111, 1'b0);
    step();
    chk("t5_busy_after", 32'(bus.busy), 32'h0);
    chk("t5_no_valid",   32'(bus.valid_out), 32'h0);
    advance();

    // asynchronous reset with two outstanding
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, FPU_OP_MUL, 32'(i), 32'h3, 1'b0, 4'b1111, 1'b0);
      step(); advance();
    end
    drive(1'b0, FPU_OP_ADD, 32'h0, 32'h0, 1'b0, 4'b1111, 1'b0);
    reset_n = 1'b0;
    model_clear();
    step();
    chk("t6_rst_valid", 32'(bus.valid_out), 32'h0);
    chk("t6_rst_busy",  32'(bus.busy), 32'h0);
    advance();
    reset_n = 1'b1;
    drive(1'b1, FPU_OP_SGNJN, 32'h3F800000, 32'h0, 1'b1, 4'b1111, 1'b0);
    step();
    chk("t6_resume_issue", 32'(bus.unit_valid_out), 32'h1);
    advance();
    drive(1'b0, FPU_OP_ADD, 32'h0, 32'h0, 1'b1, 4'b1111, 1'b0);
    step();
    chk("t6_resume_res", bus.float_out, 32'hBF800000);
    advance();

    // randomised traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 9) == 0) o = 5'(13 + $urandom_range(0, 18));
      else                           o = 5'($urandom_range(0, 12));
      drive($urandom_range(0, 9) < 7, o, $urandom, $urandom, $urandom_range(0, 9) < 7,
            NU'($urandom | $urandom), $urandom_range(0, 49) == 0);
      step(); advance();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, FPU_OP_ADD, 32'h0, 32'h0, 1'b1, 4'b1111, 1'b0);
      step(); advance();
    end
    step();
    chk("drain_empty", 32'(bus.busy), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
